// File: rtl/cve2_pkg.sv
// Shared CVE2 definitions used by the machine counter/timer unit: CSR numbers, CSR ops,
// hardware performance event indices and mcountinhibit bit positions.
package cve2_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT  = 12'h320,
        CSR_MHPMEVENT3     = 12'h323,
        CSR_MHPMEVENT31    = 12'h33F,
        CSR_MCYCLE         = 12'hB00,
        CSR_MINSTRET       = 12'hB02,
        CSR_MHPMCOUNTER3   = 12'hB03,
        CSR_MHPMCOUNTER31  = 12'hB1F,
        CSR_MCYCLEH        = 12'hB80,
        CSR_MINSTRETH      = 12'hB82,
        CSR_MHPMCOUNTER3H  = 12'hB83,
        CSR_MHPMCOUNTER31H = 12'hB9F
    } csr_num_e;

    localparam int unsigned HPM_EVENT_W = 16;

    // Event strobe indices into hpm_event_i
    localparam int unsigned HPM_EV_LOAD         = 0;
    localparam int unsigned HPM_EV_STORE        = 1;
    localparam int unsigned HPM_EV_JUMP         = 2;
    localparam int unsigned HPM_EV_BRANCH       = 3;
    localparam int unsigned HPM_EV_BRANCH_TAKEN = 4;
    localparam int unsigned HPM_EV_COMP_INSTR   = 5;
    localparam int unsigned HPM_EV_LSU_WAIT     = 6;
    localparam int unsigned HPM_EV_IMISS        = 7;
    localparam int unsigned HPM_EV_MUL_WAIT     = 8;
    localparam int unsigned HPM_EV_DIV_WAIT     = 9;

    localparam int unsigned CSR_MCNTINH_CY_BIT   = 0;
    localparam int unsigned CSR_MCNTINH_IR_BIT   = 2;
    localparam int unsigned CSR_MCNTINH_HPM_BASE = 3;

    // Value a CSR op would write, given the register's current read value
    function automatic logic [31:0] csr_wval(input csr_op_e op, input logic [31:0] old,
                                             input logic [31:0] wdata);
        logic [31:0] res;
        case (op)
            CSR_OP_WRITE: res = wdata;
            CSR_OP_SET:   res = old | wdata;
            CSR_OP_CLEAR: res = old & ~wdata;
            default:      res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cve2_counter.sv
// One machine counter of configurable width with independent low/high 32-bit write ports.
// The value is presented zero-extended to 64 bits.
module cve2_counter #(
    parameter int unsigned CounterWidth = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_en,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [CounterWidth-1:0] cnt_q;
    logic [63:0]             cur_ext;
    logic [63:0]             next_ext;

    assign cur_ext = 64'(cnt_q);
    assign value   = cur_ext;

    // A write replaces one half and suppresses the increment; the other half is untouched
    always_comb begin
        next_ext = cur_ext;
        if (we_lo) begin
            next_ext = {cur_ext[63:32], wdata};
        end else if (we_hi) begin
            next_ext = {wdata, cur_ext[31:0]};
        end else if (inc_en) begin
            next_ext = cur_ext + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= CounterWidth'(next_ext);
        end
    end

endmodule

// File: rtl/cve2_perf_counters.sv
// Machine counter/timer unit: mcycle, minstret, mhpmcounterN/mhpmeventN and mcountinhibit,
// with CSR address decode, read mux and read-modify-write ops.
module cve2_perf_counters
    import cve2_pkg::*;
#(
    parameter int unsigned MHPMCounterNum   = 2,
    parameter int unsigned MHPMCounterWidth = 40
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   csr_access_i,
    input  logic [11:0]            csr_addr_i,
    input  csr_op_e                csr_op_i,
    input  logic                   csr_op_en_i,
    input  logic [31:0]            csr_wdata_i,
    output logic [31:0]            csr_rdata_o,
    output logic                   csr_hit_o,
    input  logic                   instr_ret_i,
    input  logic [HPM_EVENT_W-1:0] hpm_event_i,
    input  logic                   debug_stopcount_i
);

    localparam int unsigned NUM_HPM_ARR  = (MHPMCounterNum > 0) ? MHPMCounterNum : 1;
    localparam logic [31:0] MCNTINH_MASK =
        32'h0000_0005 | (32'((64'd1 << MHPMCounterNum) - 64'd1) << CSR_MCNTINH_HPM_BASE);

    logic [31:0]            mcountinhibit_q;
    logic [HPM_EVENT_W-1:0] mhpmevent_q [NUM_HPM_ARR];

    logic [63:0] cycle_val;
    logic [63:0] instret_val;
    logic [63:0] hpm_val [NUM_HPM_ARR];

    logic [4:0]  idx;
    logic        hi;
    logic        sel_inh, sel_ev, sel_ctr, sel_cy, sel_ir, sel_hpm;
    logic        wr_en;
    logic [31:0] rdata;
    logic [31:0] wval;

    logic                   cy_we_lo, cy_we_hi, ir_we_lo, ir_we_hi;
    logic [NUM_HPM_ARR-1:0] hpm_we_lo, hpm_we_hi, ev_we;
    logic                   cy_inc, ir_inc;
    logic [NUM_HPM_ARR-1:0] hpm_inc;

    // Address decode: event selectors 0x323..0x33F, counters 0xB00..0xB1F and 0xB80..0xB9F
    assign idx     = csr_addr_i[4:0];
    assign hi      = csr_addr_i[7];
    assign sel_inh = (csr_addr_i == 12'(CSR_MCOUNTINHIBIT));
    assign sel_ev  = (csr_addr_i[11:5] == 7'h19) && (idx >= 5'd3);
    assign sel_ctr = (csr_addr_i[11:8] == 4'hB) && (csr_addr_i[6:5] == 2'b00);
    assign sel_cy  = sel_ctr && (idx == 5'd0);
    assign sel_ir  = sel_ctr && (idx == 5'd2);
    assign sel_hpm = sel_ctr && (idx >= 5'd3);

    assign csr_hit_o = sel_inh | sel_ev | sel_cy | sel_ir | sel_hpm;
    assign wr_en     = csr_access_i & csr_op_en_i & (csr_op_i != CSR_OP_READ);

    // Read mux; unimplemented indices fall through to zero
    always_comb begin
        rdata = '0;
        if (sel_inh) begin
            rdata = mcountinhibit_q;
        end else if (sel_cy) begin
            rdata = hi ? cycle_val[63:32] : cycle_val[31:0];
        end else if (sel_ir) begin
            rdata = hi ? instret_val[63:32] : instret_val[31:0];
        end else begin
            for (int unsigned k = 0; k < MHPMCounterNum; k++) begin
                if (sel_hpm && (idx == 5'(k + 3))) begin
                    rdata = hi ? hpm_val[k][63:32] : hpm_val[k][31:0];
                end
                if (sel_ev && (idx == 5'(k + 3))) begin
                    rdata = 32'(mhpmevent_q[k]);
                end
            end
        end
    end

    assign csr_rdata_o = rdata;
    assign wval        = csr_wval(csr_op_i, rdata, csr_wdata_i);

    always_comb begin
        cy_we_lo  = wr_en & sel_cy & ~hi;
        cy_we_hi  = wr_en & sel_cy & hi;
        ir_we_lo  = wr_en & sel_ir & ~hi;
        ir_we_hi  = wr_en & sel_ir & hi;
        hpm_we_lo = '0;
        hpm_we_hi = '0;
        ev_we     = '0;
        for (int unsigned k = 0; k < MHPMCounterNum; k++) begin
            hpm_we_lo[k] = wr_en & sel_hpm & (idx == 5'(k + 3)) & ~hi;
            hpm_we_hi[k] = wr_en & sel_hpm & (idx == 5'(k + 3)) & hi;
            ev_we[k]     = wr_en & sel_ev & (idx == 5'(k + 3));
        end
    end

    assign cy_inc = ~mcountinhibit_q[CSR_MCNTINH_CY_BIT] & ~debug_stopcount_i;
    assign ir_inc = instr_ret_i & ~mcountinhibit_q[CSR_MCNTINH_IR_BIT] & ~debug_stopcount_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcountinhibit_q <= '0;
        end else if (wr_en && sel_inh) begin
            mcountinhibit_q <= wval & MCNTINH_MASK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NUM_HPM_ARR; k++) begin
                mhpmevent_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < MHPMCounterNum; k++) begin
                if (ev_we[k]) begin
                    mhpmevent_q[k] <= wval[HPM_EVENT_W-1:0];
                end
            end
        end
    end

    cve2_counter #(.CounterWidth(64)) u_mcycle (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .inc_en (cy_inc),
        .we_lo  (cy_we_lo),
        .we_hi  (cy_we_hi),
        .wdata  (wval),
        .value  (cycle_val)
    );

    cve2_counter #(.CounterWidth(64)) u_minstret (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .inc_en (ir_inc),
        .we_lo  (ir_we_lo),
        .we_hi  (ir_we_hi),
        .wdata  (wval),
        .value  (instret_val)
    );

    if (MHPMCounterNum == 0) begin : g_no_hpm
        assign hpm_inc    = '0;
        assign hpm_val[0] = '0;
    end else begin : g_hpm
        for (genvar k = 0; k < MHPMCounterNum; k++) begin : g_ctr
            assign hpm_inc[k] = (|(hpm_event_i & mhpmevent_q[k]))
                              & ~mcountinhibit_q[CSR_MCNTINH_HPM_BASE + k]
                              & ~debug_stopcount_i;

            cve2_counter #(.CounterWidth(MHPMCounterWidth)) u_hpm (
                .clk    (clk_i),
                .rst_n  (rst_ni),
                .inc_en (hpm_inc[k]),
                .we_lo  (hpm_we_lo[k]),
                .we_hi  (hpm_we_hi[k]),
                .wdata  (wval),
                .value  (hpm_val[k])
            );
        end
    end

endmodule
